// File: rtl/coeff_loader.sv
// coeff_loader: MSB-first serial-to-parallel loader that fills the coefficient memory.
// Define COEFF_LOADER_CHECKSUM_EN to add a running modulo-2^WORD_W checksum output.
module coeff_loader #(
  parameter int WORD_W    = 16,
  parameter int NUM_COEFF = 512,
  parameter int ADDR_W    = 9
) (
  input  logic              Sclk_i,
  input  logic              Reset_n_i,
  input  logic              loadStart_i,
  input  logic              Frame_i,
  input  logic              serialIn_i,
  output logic [ADDR_W-1:0] coeffWriteAddr_o,
  output logic [WORD_W-1:0] coeffDataIn_o,
  output logic              writeEnable_o,
  output logic              busy_o,
  output logic              loadDone_o,
`ifdef COEFF_LOADER_CHECKSUM_EN
  output logic              frameErr_o,
  output logic [WORD_W-1:0] checksum_o
`else
  output logic              frameErr_o
`endif
);

  localparam int                CNT_W     = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WORD_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_COEFF - 1);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [WORD_W-2:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] nextWord;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic [ADDR_W-1:0] wordCount_q, wordCount_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              pend_q, pend_d;
  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              lastBit;

  assign lastBit  = (bitCnt_q == LAST_BIT);
  assign nextWord = {shift_q, serialIn_i};

  always_ff @(posedge Sclk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (loadStart_i) begin
      state_d = ARMED;
    end else begin
      case (state_q)
        ARMED:   if (Frame_i) state_d = SHIFT;
        SHIFT:   if (!Frame_i && lastBit)
                   state_d = (wordCount_q == LAST_ADDR) ? DONE : ARMED;
        default: state_d = state_q;
      endcase
    end
  end

  // A pending capture always turns into a strobe one edge later, even across
  // a loadStart abort, so address/data lead the rising strobe by a full cycle.
  always_comb begin
    shift_d     = shift_q;
    bitCnt_d    = bitCnt_q;
    wordCount_d = wordCount_q;
    addr_d      = addr_q;
    data_d      = data_q;
    pend_d      = 1'b0;
    we_d        = pend_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;
    if (loadStart_i) begin
      shift_d     = '0;
      bitCnt_d    = '0;
      wordCount_d = '0;
      busy_d      = 1'b1;
      done_d      = 1'b0;
      err_d       = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (Frame_i) begin
            shift_d  = {{(WORD_W-2){1'b0}}, serialIn_i};
            bitCnt_d = CNT_W'(1);
          end
        end
        SHIFT: begin
          if (Frame_i) begin
            shift_d  = {{(WORD_W-2){1'b0}}, serialIn_i};
            bitCnt_d = CNT_W'(1);
            err_d    = 1'b1;
          end else if (lastBit) begin
            data_d      = nextWord;
            addr_d      = wordCount_q;
            wordCount_d = wordCount_q + ADDR_W'(1);
            bitCnt_d    = '0;
            pend_d      = 1'b1;
          end else begin
            shift_d  = nextWord[WORD_W-2:0];
            bitCnt_d = bitCnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          if (we_q) begin
            busy_d = 1'b0;
            done_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Sclk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      shift_q     <= '0;
      bitCnt_q    <= '0;
      wordCount_q <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      bitCnt_q    <= bitCnt_d;
      wordCount_q <= wordCount_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      we_q        <= we_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign coeffWriteAddr_o = addr_q;
  assign coeffDataIn_o    = data_q;
  assign writeEnable_o    = we_q;
  assign busy_o           = busy_q;
  assign loadDone_o       = done_q;
  assign frameErr_o       = err_q;

`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] sum_q, sum_d;

  // Accumulate on the strobe edge, the same edge the memory commits the word.
  always_comb begin
    sum_d = sum_q;
    if (loadStart_i) sum_d = '0;
    else if (pend_q) sum_d = sum_q + data_q;
  end

  always_ff @(posedge Sclk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) sum_q <= '0;
    else            sum_q <= sum_d;
  end

  assign checksum_o = sum_q;
`endif

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader: random serial words checked against a
// queue model of the writes the coefficient memory should receive.
module tb_coeff_loader;

  localparam int WORD_W    = 16;
  localparam int NUM_COEFF = 512;
  localparam int ADDR_W    = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              loadStart = 1'b0;
  logic              frame = 1'b0;
  logic              sdi = 1'b0;
  logic [ADDR_W-1:0] addr;
  logic [WORD_W-1:0] data;
  logic              we, busy, done, err;
`ifdef COEFF_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] checksum;
`endif

  int passCount  = 0;
  int checkCount = 0;

  logic [ADDR_W-1:0] capAddr[$];
  logic [WORD_W-1:0] capData[$];
  int                wideStrobes = 0;
  logic              wePrev = 1'b0;

  always #5 clk = ~clk;

  coeff_loader #(.WORD_W(WORD_W), .NUM_COEFF(NUM_COEFF), .ADDR_W(ADDR_W)) dut (
    .Sclk_i          (clk),
    .Reset_n_i       (rst_n),
    .loadStart_i     (loadStart),
    .Frame_i         (frame),
    .serialIn_i      (sdi),
    .coeffWriteAddr_o(addr),
    .coeffDataIn_o   (data),
    .writeEnable_o   (we),
    .busy_o          (busy),
    .loadDone_o      (done),
`ifdef COEFF_LOADER_CHECKSUM_EN
    .frameErr_o      (err),
    .checksum_o      (checksum)
`else
    .frameErr_o      (err)
`endif
  );

  // Memory-side monitor: records every strobe and flags any strobe wider than one cycle.
  always @(negedge clk) begin
    if (we) begin
      capAddr.push_back(addr);
      capData.push_back(data);
    end
    if (we && wePrev) wideStrobes++;
    wePrev = we;
  end

  task automatic sendBit(input logic f, input logic b);
    @(negedge clk);
    frame = f;
    sdi   = b;
    @(posedge clk);
    #1;
  endtask

  task automatic sendWord(input logic [WORD_W-1:0] w);
    for (int i = WORD_W - 1; i >= 0; i--) sendBit(i == WORD_W - 1, w[i]);
  endtask

  task automatic pulseStart();
    @(negedge clk);
    loadStart = 1'b1;
    frame     = 1'b0;
    @(posedge clk);
    #1;
    loadStart = 1'b0;
  endtask

  task automatic clearCaps();
    capAddr.delete();
    capData.delete();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checkCount++;
    if ({addr, data, we, busy, done, err} !== '0)
      $display("[TB] FAIL reset_initial: got %h required 0", {addr, data, we, busy, done, err});
    else passCount++;
    @(negedge clk) rst_n = 1'b1;
    pulseStart();
    sendWord(16'h5A5A);
    for (int j = 0; j < 4; j++) sendBit(j == 0, 1'($urandom_range(1)));
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({addr, data, we, busy, done, err} !== '0)
      $display("[TB] FAIL reset_midrun: got %h required 0", {addr, data, we, busy, done, err});
    else passCount++;
    @(negedge clk) rst_n = 1'b1;
    clearCaps();
    for (int j = 0; j < 40; j++) sendBit(1'($urandom_range(1)), 1'($urandom_range(1)));
    checkCount++;
    if (capAddr.size() !== 0 || busy !== 1'b0)
      $display("[TB] FAIL reset_idle_ignored: got strobes=%0d busy=%b required 0 0", capAddr.size(), busy);
    else passCount++;
  endtask

  task automatic test_single_word();
    logic [WORD_W-1:0] w1, w2;
    pulseStart();
    clearCaps();
    checkCount++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("[TB] FAIL single_armed: got busy=%b done=%b required 1 0", busy, done);
    else passCount++;
    sendWord(16'hA5C3);
    checkCount++;
    if (data !== 16'hA5C3 || addr !== 9'd0 || we !== 1'b0)
      $display("[TB] FAIL single_e15: got data=%h addr=%0d we=%b required a5c3 0 0", data, addr, we);
    else passCount++;
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (we !== 1'b1 || data !== 16'hA5C3 || addr !== 9'd0)
      $display("[TB] FAIL single_e16: got we=%b data=%h addr=%0d required 1 a5c3 0", we, data, addr);
    else passCount++;
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (we !== 1'b0 || busy !== 1'b1 || done !== 1'b0 || capAddr.size() !== 1)
      $display("[TB] FAIL single_e17: got we=%b busy=%b done=%b strobes=%0d required 0 1 0 1",
               we, busy, done, capAddr.size());
    else passCount++;
    w1 = 16'($urandom);
    w2 = 16'($urandom);
    sendWord(w1);
    sendWord(w2);
    repeat (2) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== 3 || capAddr[1] !== 9'd1 || capData[1] !== w1 ||
        capAddr[2] !== 9'd2 || capData[2] !== w2)
      $display("[TB] FAIL single_followups: got n=%0d a1=%0d d1=%h a2=%0d d2=%h required 3 1 %h 2 %h",
               capAddr.size(), capAddr[1], capData[1], capAddr[2], capData[2], w1, w2);
    else passCount++;
  endtask

  task automatic test_full_load();
    int bad = 0;
    pulseStart();
    clearCaps();
    for (int i = 0; i < NUM_COEFF; i++) sendWord(16'(i * 3));
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (we !== 1'b1 || done !== 1'b0 || busy !== 1'b1)
      $display("[TB] FAIL full_last_e16: got we=%b done=%b busy=%b required 1 0 1", we, done, busy);
    else passCount++;
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (we !== 1'b0 || done !== 1'b1 || busy !== 1'b0)
      $display("[TB] FAIL full_last_e17: got we=%b done=%b busy=%b required 0 1 0", we, done, busy);
    else passCount++;
    checkCount++;
    if (capAddr.size() !== NUM_COEFF)
      $display("[TB] FAIL full_count: got %0d strobes required %0d", capAddr.size(), NUM_COEFF);
    else passCount++;
    for (int i = 0; i < capAddr.size() && i < NUM_COEFF; i++)
      if (capAddr[i] !== ADDR_W'(i) || capData[i] !== 16'(i * 3)) bad++;
    checkCount++;
    if (bad !== 0) $display("[TB] FAIL full_contents: got %0d bad writes required 0", bad);
    else passCount++;
    sendWord(16'hFFFF);
    repeat (3) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== NUM_COEFF || done !== 1'b1)
      $display("[TB] FAIL full_after_done: got strobes=%0d done=%b required %0d 1",
               capAddr.size(), done, NUM_COEFF);
    else passCount++;
  endtask

  task automatic test_frame_error();
    logic [WORD_W-1:0] expData[$];
    logic [WORD_W-1:0] w;
    int bad = 0;
    pulseStart();
    clearCaps();
    for (int i = 0; i < 5; i++) begin
      w = 16'($urandom);
      expData.push_back(w);
      sendWord(w);
    end
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL ferr_clean: got frameErr=%b required 0", err);
    else passCount++;
    for (int j = 0; j < 7; j++) sendBit(j == 0, 1'($urandom_range(1)));
    sendWord(16'h1234);
    repeat (2) sendBit(1'b0, 1'b0);
    checkCount++;
    if (err !== 1'b1) $display("[TB] FAIL ferr_flag: got frameErr=%b required 1", err);
    else passCount++;
    for (int i = 0; i < 5 && i < capAddr.size(); i++)
      if (capAddr[i] !== ADDR_W'(i) || capData[i] !== expData[i]) bad++;
    checkCount++;
    if (capAddr.size() !== 6 || bad !== 0 || capAddr[5] !== 9'd5 || capData[5] !== 16'h1234)
      $display("[TB] FAIL ferr_writes: got n=%0d bad=%0d a5=%0d d5=%h required 6 0 5 1234",
               capAddr.size(), bad, capAddr[5], capData[5]);
    else passCount++;
    pulseStart();
    checkCount++;
    if (err !== 1'b0) $display("[TB] FAIL ferr_cleared: got frameErr=%b required 0", err);
    else passCount++;
  endtask

  task automatic test_abort_restart();
    pulseStart();
    clearCaps();
    for (int j = 0; j < 3; j++) sendBit(j == 0, 1'($urandom_range(1)));
    for (int i = 0; i < 100; i++) sendWord(16'($urandom));
    for (int j = 0; j < 5; j++) sendBit(j == 0, 1'($urandom_range(1)));
    pulseStart();
    repeat (3) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== 100 || busy !== 1'b1 || err !== 1'b0)
      $display("[TB] FAIL abort_state: got strobes=%0d busy=%b frameErr=%b required 100 1 0",
               capAddr.size(), busy, err);
    else passCount++;
    sendWord(16'hBEEF);
    repeat (2) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== 101 || capAddr[100] !== 9'd0 || capData[100] !== 16'hBEEF)
      $display("[TB] FAIL abort_restart_write: got n=%0d addr=%0d data=%h required 101 0 beef",
               capAddr.size(), capAddr[100], capData[100]);
    else passCount++;
    for (int i = 1; i < 200; i++) sendWord(16'($urandom));
    for (int j = 0; j < 6; j++) sendBit(j == 0, 1'($urandom_range(1)));
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if ({addr, data, we, busy, done, err} !== '0)
      $display("[TB] FAIL abort_reset_outputs: got %h required 0", {addr, data, we, busy, done, err});
    else passCount++;
    @(negedge clk) rst_n = 1'b1;
    repeat (20) sendBit(1'($urandom_range(1)), 1'($urandom_range(1)));
    checkCount++;
    if (capAddr.size() !== 300 || capAddr[299] !== 9'd199)
      $display("[TB] FAIL abort_reset_nostrobe: got n=%0d last_addr=%0d required 300 199",
               capAddr.size(), capAddr[299]);
    else passCount++;
    pulseStart();
    sendWord(16'($urandom));
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (we !== 1'b1) $display("[TB] FAIL strobe_before_reset: got we=%b required 1", we);
    else passCount++;
    #2 rst_n = 1'b0;
    #1;
    checkCount++;
    if (we !== 1'b0) $display("[TB] FAIL strobe_reset_drop: got we=%b required 0", we);
    else passCount++;
    @(negedge clk) rst_n = 1'b1;
    repeat (5) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== 300)
      $display("[TB] FAIL strobe_reset_after: got n=%0d required 300", capAddr.size());
    else passCount++;
  endtask

  task automatic test_random();
    logic [WORD_W-1:0] expData[$];
    logic [WORD_W-1:0] w;
    logic [WORD_W-1:0] expSum = '0;
    logic              expErr = 1'b0;
    int                bad = 0;
    int                k;
    pulseStart();
    clearCaps();
    for (int n = 0; n < 40; n++) begin
      w = 16'($urandom);
      if ($urandom_range(5) == 0) begin
        k = $urandom_range(15, 1);
        for (int j = 0; j < k; j++) sendBit(j == 0, 1'($urandom_range(1)));
        expErr = 1'b1;
      end
      sendWord(w);
      expData.push_back(w);
      expSum = expSum + w;
      repeat ($urandom_range(3)) sendBit(1'b0, 1'($urandom_range(1)));
    end
    repeat (3) sendBit(1'b0, 1'b0);
    checkCount++;
    if (capAddr.size() !== expData.size())
      $display("[TB] FAIL random_count: got %0d strobes required %0d", capAddr.size(), expData.size());
    else passCount++;
    for (int i = 0; i < capAddr.size() && i < expData.size(); i++)
      if (capAddr[i] !== ADDR_W'(i) || capData[i] !== expData[i]) bad++;
    checkCount++;
    if (bad !== 0) $display("[TB] FAIL random_contents: got %0d bad writes required 0", bad);
    else passCount++;
    checkCount++;
    if (err !== expErr) $display("[TB] FAIL random_frameerr: got %b required %b", err, expErr);
    else passCount++;
`ifdef COEFF_LOADER_CHECKSUM_EN
    checkCount++;
    if (checksum !== expSum) $display("[TB] FAIL random_checksum: got %h required %h", checksum, expSum);
    else passCount++;
`else
    if (expSum === 16'h0) $display("[TB] note: random words summed to zero");
`endif
  endtask

`ifdef COEFF_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    pulseStart();
    checkCount++;
    if (checksum !== 16'h0) $display("[TB] FAIL checksum_clear: got %h required 0", checksum);
    else passCount++;
    sendWord(16'hFFFF);
    sendWord(16'h0002);
    sendWord(16'h1000);
    sendBit(1'b0, 1'b0);
    checkCount++;
    if (checksum !== 16'h1001) $display("[TB] FAIL checksum_sum: got %h required 1001", checksum);
    else passCount++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_word();
    test_full_load();
    test_frame_error();
    test_abort_restart();
    test_random();
`ifdef COEFF_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    checkCount++;
    if (wideStrobes !== 0) $display("[TB] FAIL strobe_width: got %0d wide strobes required 0", wideStrobes);
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/coeff_loader.md
Name: coeff_loader

Overview:
- Serial-to-parallel front end that fills the 512-entry coefficient memory during the MSDAP coefficient-load phase.
- Deserialises MSB-first 16-bit words framed by Frame on Sclk.
- For each word, drives write address and data, then issues one clean writeEnable pulse. The memory writes on the rising edge of that pulse, so address and data must be stable before it.
- Sits directly upstream of the coefficient memory. The main controller triggers it with loadStart and waits on loadDone.

Parameters:
- WORD_W, 16: coefficient word width, bits per serial word.
- NUM_COEFF, 512: words per load; last address is NUM_COEFF-1.
- ADDR_W, 9: write-address width; must satisfy 2^ADDR_W >= NUM_COEFF.

Ports:
- Sclk  input  1  system clock; all state changes on rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- loadStart  input  1  one-cycle pulse; arms a new load starting at address 0.
- Frame  input  1  high in the cycle carrying a word's MSB.
- serialIn  input  1  serial data, sampled on Sclk rising edge.
- coeffWriteAddr  output  ADDR_W  memory write address.
- coeffDataIn  output  WORD_W  memory write data.
- writeEnable  output  1  write strobe, one Sclk cycle wide.
- busy  output  1  load armed and in progress.
- loadDone  output  1  sticky; all NUM_COEFF words written.
- frameErr  output  1  sticky; a Frame arrived mid-word.

Behaviour:
- Reset (Reset_n low, any time, asynchronous): all outputs, counters and the shift register clear to 0; state = IDLE.
- Deserialiser states:
  - IDLE: Frame and serialIn ignored. loadStart -> ARMED; wordCount=0; busy=1; loadDone=0; frameErr=0.
  - ARMED: waits for Frame. On Frame, bit 15 is sampled and bitCnt=1 -> SHIFT.
  - SHIFT: samples one bit per cycle, MSB first.
- Word capture: at the edge sampling bit 0 (E15, the 16th edge counted from the Frame edge E0):
  - coeffDataIn <= assembled word; coeffWriteAddr <= wordCount; wordCount increments.
  - State -> ARMED, or -> DONE if this was word NUM_COEFF-1.
- Write sequencer, independent of the deserialiser:
  - writeEnable=1 from E16 to E17, exactly one cycle.
  - coeffDataIn and coeffWriteAddr stay unchanged until the next word's E15, so they are stable one full cycle before the rising strobe and throughout it.
- Back-to-back words: a Frame at E16 (next MSB immediately after the LSB) must be accepted with no lost bits. Strobe latency is 2 cycles, well inside the 16-cycle word period.
- Frame during SHIFT (bitCnt 1..15):
  - The partial word is discarded and not written; wordCount is unchanged.
  - frameErr=1 (sticky until loadStart or reset).
  - The current bit is taken as the MSB of a new word.
- DONE: entered after the last capture.
  - loadDone=1 at E17 of the last word; busy=0 at the same edge.
  - Further Frames are ignored.
  - loadStart -> ARMED with loadDone cleared.
- loadStart while busy: aborts the current load.
  - Partial word dropped; wordCount=0; frameErr cleared; no strobe for the partial word.
  - A strobe already scheduled for E16 still completes.
- Address range: addresses are always in 0..NUM_COEFF-1 and never wrap within a load.
- Reset asserted during a strobe: writeEnable falls immediately; no further strobe follows.

Optional Feature:
- Macro: COEFF_LOADER_CHECKSUM_EN.
- Defined:
  - Adds output port checksum, WORD_W wide: modulo-2^WORD_W sum of every word written in the current load.
  - The sum updates at E16 of each word.
  - Cleared by reset and by loadStart.
  - Final value valid when loadDone=1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold Reset_n low mid-run -> all outputs 0; toggling Frame/serialIn with no loadStart -> writeEnable never asserts.
- Single word: loadStart, then Frame with 0xA5C3 MSB-first -> coeffDataIn=0xA5C3 and coeffWriteAddr=0 at E15; writeEnable high exactly E16 to E17; busy=1, loadDone=0.
- Full load: 512 back-to-back words, word i = (i*3) mod 65536 -> 512 strobes at addresses 0..511 with matching data; loadDone=1 and busy=0 at E17 of word 511; extra Frame afterwards -> no strobe.
- Framing error: Frame re-asserted at bitCnt=7 of word 5 -> no strobe for the partial word; frameErr=1; following complete word 0x1234 written to address 5.
- Abort/restart: loadStart at word 100, then a new word 0xBEEF -> written to address 0; reset at word 200 -> no strobe, outputs 0.
- With COEFF_LOADER_CHECKSUM_EN: words 0xFFFF, 0x0002, 0x1000 -> checksum=0x1001 after the third strobe.
